booth_r16_prep: RTL and testbench
=================================

# booth_r16_prep

Input stage of the radix-16 Booth 8×8 signed multiplier; sits directly upstream of the compute unit. Accepts a signed multiplicand/multiplier pair over a valid/ready handshake. Precomputes the odd multiples 1X/3X/5X/7X of the multiplicand and encodes the multiplier into two radix-16 Booth digits, each expressed as sign, one-hot odd-multiple select and one-hot shift. Results are registered behind a two-entry skid buffer, so every output is driven directly from a flop.

## Interface
- TAG_W, 4, width of the sideband tag carried alongside each operand pair (≥1)
- iClk  in  1  clock, rising edge
- iRst  in  1  reset, asynchronous, active-high
- iValid  in  1  input beat valid
- oReady  out  1  stage can accept a beat; driven from a flop
- iDatA  in  8  multiplicand, signed two's complement
- iDatB  in  8  multiplier, signed two's complement
- iTag  in  TAG_W  sideband, passed through unchanged
- oValid  out  1  output beat valid
- iReady  in  1  downstream accepts the beat
- oDat1X  out  8  A
- oDat3X  out  10  3·A, signed
- oDat5X  out  11  5·A, signed
- oDat7X  out  11  7·A, signed
- oNegative  out  [1:0]  digit sign; [1] = high digit, [0] = low digit
- oBoothSel  out  [1:0][3:0]  one-hot odd-multiple select, bit0..3 = 1X/3X/5X/7X; all-zero for digit 0
- oShiftSel  out  [1:0][3:0]  one-hot left shift, bit k = shift k (0..3)
- oTag  out  TAG_W  tag of the presented beat

## Operation
- Multiples: 3A = (A<<1)+A, 5A = (A<<2)+A, 7A = (A<<3)−A. Each is sign-extended to its output width. No overflow occurs: 7·(−128) = −896 fits 11 bits.
- Digit value: d = −8·b[i+3] + 4·b[i+2] + 2·b[i+1] + b[i] + b[i−1].
  - Low digit: i=0, with b[−1]=0.
  - High digit: i=4, window {B[7:3]}.
  - Range −8..+8.
- Encoding of |d|:
  - 1 → 1X, shift0
  - 2 → 1X, shift1
  - 3 → 3X, shift0
  - 4 → 1X, shift2
  - 5 → 5X, shift0
  - 6 → 3X, shift1
  - 7 → 7X, shift0
  - 8 → 1X, shift3
  - 0 → BoothSel=0000, ShiftSel=0001, Negative=0
- oNegative = 1 only for d<0; an all-ones window (d = 0) gives 0.
- Encoding and multiples are computed combinationally on the input side. Only finished fields are stored.
- Skid buffer has a main register, which drives the outputs, and a skid register. States:
  - EMPTY: accept → BUSY.
  - BUSY:
    - accept & iReady → BUSY (main reloaded from input)
    - accept & !iReady → FULL (beat into skid)
    - !accept & iReady → EMPTY
    - otherwise hold
  - FULL: iReady → BUSY (skid → main). No accept is possible because oReady = 0.
- accept = iValid & oReady. Output transfer = oValid & iReady. oValid = (state ≠ EMPTY). oReady = (state ≠ FULL), registered.
- While oValid & !iReady, every output field holds stable. Ordering is strictly FIFO; no beat is dropped or duplicated.

## Timing
- Latency: 1 cycle. A beat accepted at edge n is presented on the outputs after edge n.
- Throughput: 1 beat/cycle when iReady stays high.
- oReady falls in the cycle after the accept that fills the skid register. It rises in the cycle after the FULL→BUSY drain.
- On iRst assertion, immediately and asynchronously:
  - state = EMPTY, oValid = 0, oReady = 1
  - all data outputs and oTag = 0, oShiftSel = 0
  - in-flight beats, including a held skid entry, are discarded
- First accept is possible on the first rising edge after iRst deasserts.

## Structure
- Package booth_r16_pkg holds:
  - widths: DAT_W=8, W3X=10, W5X=11, W7X=11
  - typedef for the 4-bit one-hot select
  - one-hot constants SEL_1X..SEL_7X and SH_0..SH_3
  - state enum {EMPTY, BUSY, FULL}
- Sub-module booth_r16_digit_enc is combinational: 5-bit window in → negative, boothSel, shiftSel out. It is instantiated twice.
- The skid buffer is inline.

## Test plan
- A=0x05, B=0x03, iReady=1 → one cycle later:
  - oDat3X=0x00F, oDat5X=0x019, oDat7X=0x023
  - low digit: Sel=0010, Shift=0001, Neg=0
  - high digit: Sel=0000, Neg=0
- A=0x7F, B=0x80 →
  - low digit: Sel=0000
  - high digit: Neg=1, Sel=0001, Shift=1000
  - downstream product 0xC080 (−16256)
- A=0x80, B=0x0F →
  - oDat3X=0x280, oDat5X=0x580, oDat7X=0x480
  - low digit: Neg=1, 1X, shift0
  - high digit: Neg=0, 1X, shift0
  - B=0xFF gives high digit Neg=0, Sel=0000
- iReady=0; drive tags 1, 2, 3 back-to-back →
  - tag 1 is held in main, tag 2 goes to skid
  - oReady=0 from the cycle after the tag-2 accept; tag 3 waits
  - raise iReady → tags 1, 2, 3 appear in order, one per cycle
- Continuous iValid/iReady for 16 beats with random A/B → 16 output beats back-to-back, 1-cycle latency. Each beat matches a reference model, including A·B through the downstream compute unit.
- Reach FULL, then pulse iRst asynchronously mid-cycle → oValid=0 and oReady=1 before the next edge. After release, the next accepted beat is the first one output.

Source files
------------

// File: rtl/booth_r16_pkg.sv
// rtl/booth_r16_pkg.sv - shared widths, one-hot constants, state enum and stored-beat struct for booth_r16_prep
package booth_r16_pkg;

  localparam int DAT_W = 8;
  localparam int W3X   = 10;
  localparam int W5X   = 11;
  localparam int W7X   = 11;

  typedef logic [3:0] sel_t;

  localparam sel_t SEL_NONE = 4'b0000;
  localparam sel_t SEL_1X   = 4'b0001;
  localparam sel_t SEL_3X   = 4'b0010;
  localparam sel_t SEL_5X   = 4'b0100;
  localparam sel_t SEL_7X   = 4'b1000;

  localparam sel_t SH_0 = 4'b0001;
  localparam sel_t SH_1 = 4'b0010;
  localparam sel_t SH_2 = 4'b0100;
  localparam sel_t SH_3 = 4'b1000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Finished fields of one beat, as held in the main and skid registers
  typedef struct packed {
    logic [DAT_W-1:0] m1;
    logic [W3X-1:0]   m3;
    logic [W5X-1:0]   m5;
    logic [W7X-1:0]   m7;
    logic [1:0]       neg;
    sel_t [1:0]       sel;
    sel_t [1:0]       sh;
  } prep_t;

endpackage

// File: rtl/booth_r16_digit_enc.sv
// rtl/booth_r16_digit_enc.sv - combinational radix-16 Booth digit encoder for one 5-bit multiplier window
module booth_r16_digit_enc
  import booth_r16_pkg::*;
(
  input  logic [4:0] win_i,
  output logic       negative_o,
  output sel_t       booth_sel_o,
  output sel_t       shift_sel_o
);

  logic [4:0] digit;
  logic [4:0] mag;

  // Window value is the signed top four bits plus the borrowed lower bit; encode its magnitude
  always_comb begin
    digit       = {win_i[4], win_i[4:1]} + {4'b0000, win_i[0]};
    negative_o  = digit[4];
    mag         = digit[4] ? (5'd0 - digit) : digit;
    booth_sel_o = SEL_NONE;
    shift_sel_o = SH_0;
    case (mag)
      5'd1: begin booth_sel_o = SEL_1X; shift_sel_o = SH_0; end
      5'd2: begin booth_sel_o = SEL_1X; shift_sel_o = SH_1; end
      5'd3: begin booth_sel_o = SEL_3X; shift_sel_o = SH_0; end
      5'd4: begin booth_sel_o = SEL_1X; shift_sel_o = SH_2; end
      5'd5: begin booth_sel_o = SEL_5X; shift_sel_o = SH_0; end
      5'd6: begin booth_sel_o = SEL_3X; shift_sel_o = SH_1; end
      5'd7: begin booth_sel_o = SEL_7X; shift_sel_o = SH_0; end
      5'd8: begin booth_sel_o = SEL_1X; shift_sel_o = SH_3; end
      default: begin end
    endcase
  end

endmodule

// File: rtl/booth_r16_prep.sv
// rtl/booth_r16_prep.sv - radix-16 Booth 8x8 input stage: odd multiples, digit encoding, two-entry skid buffer
module booth_r16_prep
  import booth_r16_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  output logic              oReady,
  input  logic [7:0]        iDatA,
  input  logic [7:0]        iDatB,
  input  logic [TAG_W-1:0]  iTag,
  output logic              oValid,
  input  logic              iReady,
  output logic [7:0]        oDat1X,
  output logic [9:0]        oDat3X,
  output logic [10:0]       oDat5X,
  output logic [10:0]       oDat7X,
  output logic [1:0]        oNegative,
  output logic [1:0][3:0]   oBoothSel,
  output logic [1:0][3:0]   oShiftSel,
  output logic [TAG_W-1:0]  oTag
);

  prep_t      in_fields;
  logic [9:0]  a_x10;
  logic [10:0] a_x11;
  logic        neg_lo, neg_hi;
  sel_t        sel_lo, sel_hi, sh_lo, sh_hi;

  state_e             state_q, state_d;
  prep_t              main_q, main_d, skid_q, skid_d;
  logic [TAG_W-1:0]   main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
  logic               valid_q, ready_q;
  logic               accept, xfer;

  booth_r16_digit_enc u_enc_lo (
    .win_i       ({iDatB[3:0], 1'b0}),
    .negative_o  (neg_lo),
    .booth_sel_o (sel_lo),
    .shift_sel_o (sh_lo)
  );

  booth_r16_digit_enc u_enc_hi (
    .win_i       (iDatB[7:3]),
    .negative_o  (neg_hi),
    .booth_sel_o (sel_hi),
    .shift_sel_o (sh_hi)
  );

  // Odd multiples and digit encodings of the incoming beat, ready to be stored
  always_comb begin
    a_x10         = {{2{iDatA[7]}}, iDatA};
    a_x11         = {{3{iDatA[7]}}, iDatA};
    in_fields.m1  = iDatA;
    in_fields.m3  = (a_x10 << 1) + a_x10;
    in_fields.m5  = (a_x11 << 2) + a_x11;
    in_fields.m7  = (a_x11 << 3) - a_x11;
    in_fields.neg = {neg_hi, neg_lo};
    in_fields.sel = {sel_hi, sel_lo};
    in_fields.sh  = {sh_hi, sh_lo};
  end

  assign accept = iValid & ready_q;
  assign xfer   = valid_q & iReady;

  // Skid-buffer next state: main always presents the oldest beat, skid holds the one behind it
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    main_tag_d = main_tag_q;
    skid_d     = skid_q;
    skid_tag_d = skid_tag_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = BUSY;
          main_d     = in_fields;
          main_tag_d = iTag;
        end
      end
      BUSY: begin
        if (accept && iReady) begin
          main_d     = in_fields;
          main_tag_d = iTag;
        end else if (accept) begin
          state_d    = FULL;
          skid_d     = in_fields;
          skid_tag_d = iTag;
        end else if (iReady) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          state_d    = BUSY;
          main_d     = skid_q;
          main_tag_d = skid_tag_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, handshake flags and stored beats; reset discards everything in flight
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= EMPTY;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      main_q     <= '0;
      main_tag_q <= '0;
      skid_q     <= '0;
      skid_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= (state_d != EMPTY);
      ready_q    <= (state_d != FULL);
      main_q     <= main_d;
      main_tag_q <= main_tag_d;
      skid_q     <= skid_d;
      skid_tag_q <= skid_tag_d;
    end
  end

  assign oReady    = ready_q;
  assign oValid    = valid_q;
  assign oDat1X    = main_q.m1;
  assign oDat3X    = main_q.m3;
  assign oDat5X    = main_q.m5;
  assign oDat7X    = main_q.m7;
  assign oNegative = main_q.neg;
  assign oBoothSel = main_q.sel;
  assign oShiftSel = main_q.sh;
  assign oTag      = main_tag_q;

endmodule

// File: tb/tb_booth_r16_prep.sv
// tb/tb_booth_r16_prep.sv - scoreboard testbench for booth_r16_prep
module tb_booth_r16_prep;

  localparam int TAG_W = 4;

  logic              iClk;
  logic              iRst;
  logic              iValid;
  logic              oReady;
  logic [7:0]        iDatA;
  logic [7:0]        iDatB;
  logic [TAG_W-1:0]  iTag;
  logic              oValid;
  logic              iReady;
  logic [7:0]        oDat1X;
  logic [9:0]        oDat3X;
  logic [10:0]       oDat5X;
  logic [10:0]       oDat7X;
  logic [1:0]        oNegative;
  logic [1:0][3:0]   oBoothSel;
  logic [1:0][3:0]   oShiftSel;
  logic [TAG_W-1:0]  oTag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } beat_t;

  beat_t sb[$];

  booth_r16_prep #(.TAG_W(TAG_W)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iValid    (iValid),
    .oReady    (oReady),
    .iDatA     (iDatA),
    .iDatB     (iDatB),
    .iTag      (iTag),
    .oValid    (oValid),
    .iReady    (iReady),
    .oDat1X    (oDat1X),
    .oDat3X    (oDat3X),
    .oDat5X    (oDat5X),
    .oDat7X    (oDat7X),
    .oNegative (oNegative),
    .oBoothSel (oBoothSel),
    .oShiftSel (oShiftSel),
    .oTag      (oTag)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic void model_digit(input logic [4:0] w, output logic ng,
                                      output logic [3:0] sl, output logic [3:0] sf);
    int d;
    int m;
    d  = -8 * int'(w[4]) + 4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
    ng = (d < 0);
    m  = (d < 0) ? -d : d;
    case (m)
      1: begin sl = 4'b0001; sf = 4'b0001; end
      2: begin sl = 4'b0001; sf = 4'b0010; end
      3: begin sl = 4'b0010; sf = 4'b0001; end
      4: begin sl = 4'b0001; sf = 4'b0100; end
      5: begin sl = 4'b0100; sf = 4'b0001; end
      6: begin sl = 4'b0010; sf = 4'b0010; end
      7: begin sl = 4'b1000; sf = 4'b0001; end
      8: begin sl = 4'b0001; sf = 4'b1000; end
      default: begin sl = 4'b0000; sf = 4'b0001; end
    endcase
  endfunction

  // Downstream compute unit: rebuild A*B from the presented multiples and digit encodings
  function automatic int recon(input logic signed [7:0] x1, input logic signed [9:0] x3,
                               input logic signed [10:0] x5, input logic signed [10:0] x7,
                               input logic [1:0] ng, input logic [1:0][3:0] sl,
                               input logic [1:0][3:0] sf);
    int tot;
    int m;
    tot = 0;
    for (int k = 0; k < 2; k++) begin
      case (sl[k])
        4'b0001: m = int'(x1);
        4'b0010: m = int'(x3);
        4'b0100: m = int'(x5);
        4'b1000: m = int'(x7);
        default: m = 0;
      endcase
      for (int j = 0; j < 4; j++) if (sf[k][j]) m = m * (1 << j);
      if (ng[k]) m = -m;
      tot += (k == 1) ? m * 16 : m;
    end
    return tot;
  endfunction

  // Scoreboard: push on accept, pop and compare on output transfer (sampled mid-cycle)
  always @(negedge iClk) begin
    beat_t       e;
    int          t;
    int          prod;
    logic [9:0]  x3;
    logic [10:0] x5, x7;
    logic        ng_lo, ng_hi;
    logic [3:0]  sl_lo, sl_hi, sf_lo, sf_hi;
    if (!iRst) begin
      if (oValid && iReady) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: output tag=%0d with empty scoreboard", oTag);
        end else begin
          e = sb.pop_front();
          t = int'($signed(e.a)) * 3; x3 = t[9:0];
          t = int'($signed(e.a)) * 5; x5 = t[10:0];
          t = int'($signed(e.a)) * 7; x7 = t[10:0];
          model_digit({e.b[3:0], 1'b0}, ng_lo, sl_lo, sf_lo);
          model_digit(e.b[7:3], ng_hi, sl_hi, sf_hi);
          checks++;
          if ({oDat1X, oDat3X, oDat5X, oDat7X} !== {e.a, x3, x5, x7}) begin
            errors++;
            $display("FAIL sb_multiples: got %h %h %h %h want %h %h %h %h",
                     oDat1X, oDat3X, oDat5X, oDat7X, e.a, x3, x5, x7);
          end
          checks++;
          if ({oNegative, oBoothSel, oShiftSel} !== {ng_hi, ng_lo, sl_hi, sl_lo, sf_hi, sf_lo}) begin
            errors++;
            $display("FAIL sb_encoding: B=%h got neg=%b sel=%b sh=%b want neg=%b sel=%b_%b sh=%b_%b",
                     e.b, oNegative, oBoothSel, oShiftSel, {ng_hi, ng_lo}, sl_hi, sl_lo, sf_hi, sf_lo);
          end
          checks++;
          if (oTag !== e.tag) begin
            errors++;
            $display("FAIL sb_tag: got %0d want %0d", oTag, e.tag);
          end
          prod = int'($signed(e.a)) * int'($signed(e.b));
          checks++;
          if (recon(oDat1X, oDat3X, oDat5X, oDat7X, oNegative, oBoothSel, oShiftSel) !== prod) begin
            errors++;
            $display("FAIL sb_product: A=%h B=%h got %0d want %0d", e.a, e.b,
                     recon(oDat1X, oDat3X, oDat5X, oDat7X, oNegative, oBoothSel, oShiftSel), prod);
          end
        end
      end
      if (iValid && oReady) begin
        e.a = iDatA; e.b = iDatB; e.tag = iTag;
        sb.push_back(e);
      end
    end
  end

  task automatic drive_one(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] tag);
    iValid = 1'b1; iDatA = a; iDatB = b; iTag = tag;
    @(posedge iClk); #1;
    iValid = 1'b0;
  endtask

  task automatic test_reset;
    iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iDatA = '0; iDatB = '0; iTag = '0;
    #2;
    checks++;
    if ({oValid, oReady} !== 2'b01) begin
      errors++; $display("FAIL reset_flags: got valid/ready=%b want 01", {oValid, oReady});
    end
    checks++;
    if ({oDat1X, oDat3X, oDat5X, oDat7X, oNegative, oBoothSel, oShiftSel, oTag} !== '0) begin
      errors++; $display("FAIL reset_data: got shift=%b sel=%b tag=%0d want all zero", oShiftSel, oBoothSel, oTag);
    end
    @(posedge iClk); #1;
    iRst = 1'b0;
  endtask

  task automatic test_vectors;
    iReady = 1'b1;
    drive_one(8'h05, 8'h03, 4'd1);
    checks++;
    if ({oValid, oDat3X, oDat5X, oDat7X} !== {1'b1, 10'h00F, 11'h019, 11'h023}) begin
      errors++; $display("FAIL vec1_mult: got v=%b %h %h %h want 1 00f 019 023", oValid, oDat3X, oDat5X, oDat7X);
    end
    checks++;
    if ({oNegative, oBoothSel[1], oBoothSel[0], oShiftSel[0]} !== {2'b00, 4'b0000, 4'b0010, 4'b0001}) begin
      errors++; $display("FAIL vec1_enc: got neg=%b sel=%b sh=%b", oNegative, oBoothSel, oShiftSel);
    end
    drive_one(8'h7F, 8'h80, 4'd2);
    checks++;
    if ({oBoothSel[0], oNegative[1], oBoothSel[1], oShiftSel[1]} !== {4'b0000, 1'b1, 4'b0001, 4'b1000}) begin
      errors++; $display("FAIL vec2_enc: got neg=%b sel=%b sh=%b", oNegative, oBoothSel, oShiftSel);
    end
    drive_one(8'h80, 8'h0F, 4'd3);
    checks++;
    if ({oDat3X, oDat5X, oDat7X} !== {10'h280, 11'h580, 11'h480}) begin
      errors++; $display("FAIL vec3_mult: got %h %h %h want 280 580 480", oDat3X, oDat5X, oDat7X);
    end
    checks++;
    if ({oNegative, oBoothSel, oShiftSel} !== {2'b01, 4'b0001, 4'b0001, 4'b0001, 4'b0001}) begin
      errors++; $display("FAIL vec3_enc: got neg=%b sel=%b sh=%b", oNegative, oBoothSel, oShiftSel);
    end
    drive_one(8'h11, 8'hFF, 4'd4);
    checks++;
    if ({oNegative, oBoothSel, oShiftSel} !== {2'b01, 4'b0000, 4'b0001, 4'b0001, 4'b0001}) begin
      errors++; $display("FAIL vec4_allones: got neg=%b sel=%b sh=%b", oNegative, oBoothSel, oShiftSel);
    end
    @(posedge iClk); #1;
  endtask

  task automatic test_back_to_back;
    iReady = 1'b0;
    drive_one(8'h21, 8'h34, 4'd1);
    checks++;
    if ({oValid, oReady, oTag} !== {2'b11, 4'd1}) begin
      errors++; $display("FAIL bp_first: got v=%b r=%b tag=%0d want 1 1 1", oValid, oReady, oTag);
    end
    drive_one(8'hC3, 8'h9A, 4'd2);
    checks++;
    if ({oReady, oTag} !== {1'b0, 4'd1}) begin
      errors++; $display("FAIL bp_full: got r=%b tag=%0d want 0 1", oReady, oTag);
    end
    iValid = 1'b1; iDatA = 8'h5E; iDatB = 8'h77; iTag = 4'd3;
    for (int i = 0; i < 2; i++) begin
      @(posedge iClk); #1;
      checks++;
      if ({oValid, oReady, oTag, oDat1X} !== {2'b10, 4'd1, 8'h21}) begin
        errors++; $display("FAIL bp_hold: got v=%b r=%b tag=%0d a=%h want 1 0 1 21", oValid, oReady, oTag, oDat1X);
      end
    end
    iReady = 1'b1;
    @(posedge iClk); #1;
    checks++;
    if ({oValid, oReady, oTag} !== {2'b11, 4'd2}) begin
      errors++; $display("FAIL bp_drain: got v=%b r=%b tag=%0d want 1 1 2", oValid, oReady, oTag);
    end
    @(posedge iClk); #1;
    iValid = 1'b0;
    checks++;
    if ({oValid, oTag} !== {1'b1, 4'd3}) begin
      errors++; $display("FAIL bp_third: got v=%b tag=%0d want 1 3", oValid, oTag);
    end
    @(posedge iClk); #1;
    checks++;
    if (oValid !== 1'b0) begin
      errors++; $display("FAIL bp_empty: got v=%b want 0", oValid);
    end
  endtask

  task automatic test_stream;
    iReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iValid = 1'b1;
      iDatA  = (i == 0) ? 8'h80 : 8'($urandom);
      iDatB  = (i == 0) ? 8'h80 : 8'($urandom);
      iTag   = 4'(i);
      @(posedge iClk); #1;
      checks++;
      if ({oValid, oTag} !== {1'b1, 4'(i)}) begin
        errors++; $display("FAIL stream_beat%0d: got v=%b tag=%0d want 1 %0d", i, oValid, oTag, i);
      end
    end
    iValid = 1'b0;
    @(posedge iClk); #1;
    checks++;
    if ({oValid, 32'(sb.size())} !== {1'b0, 32'd0}) begin
      errors++; $display("FAIL stream_drain: got v=%b pending=%0d want 0 0", oValid, sb.size());
    end
  endtask

  task automatic test_reset_mid;
    iReady = 1'b0;
    drive_one(8'h12, 8'h34, 4'd5);
    drive_one(8'h56, 8'h78, 4'd6);
    checks++;
    if (oReady !== 1'b0) begin
      errors++; $display("FAIL rst_mid_full: got r=%b want 0", oReady);
    end
    #2;
    iRst = 1'b1;
    #1;
    checks++;
    if ({oValid, oReady, oTag} !== {2'b01, 4'd0}) begin
      errors++; $display("FAIL rst_mid_async: got v=%b r=%b tag=%0d want 0 1 0", oValid, oReady, oTag);
    end
    sb.delete();
    @(posedge iClk); #1;
    iRst = 1'b0;
    iReady = 1'b1;
    drive_one(8'hE7, 8'h4C, 4'd9);
    checks++;
    if ({oValid, oTag} !== {1'b1, 4'd9}) begin
      errors++; $display("FAIL rst_mid_first: got v=%b tag=%0d want 1 9", oValid, oTag);
    end
    @(posedge iClk); #1;
    checks++;
    if ({oValid, 32'(sb.size())} !== {1'b0, 32'd0}) begin
      errors++; $display("FAIL rst_mid_drain: got v=%b pending=%0d want 0 0", oValid, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
